arbitro_escrita_regs: RTL and testbench

Write-port arbiter and scoreboard for the 32x32 register bank. It merges two writeback requesters onto the bank's single write port: the single-cycle ALU path and the memory/load return path. The ALU path is buffered in a small FIFO. The block also tracks registers with outstanding loads and drives a read-hazard stall for the decode stage. It sits between writeback and the bank's `we`/`waddr`/`wdata` inputs.

---
 rtl/sica_pkg.sv | 9 +
 rtl/fila_escrita.sv | 57 +++++
 rtl/arbitro_escrita_regs.sv | 88 ++++++++
 tb/tb_arbitro_escrita_regs.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sica_pkg.sv
// sica_pkg: shared widths and register-write record for the register bank write path
package sica_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_t;
endpackage

// File: rtl/fila_escrita.sv
// fila_escrita: synchronous write FIFO exposing every slot and its valid bit for hazard checks
module fila_escrita
  import sica_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  wr_t                   din,
  output wr_t                   dout,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count,
  output wr_t [DEPTH-1:0]       entries,
  output logic [DEPTH-1:0]      valid
);
  wr_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    push_ok = push && !full;
    pop_ok = pop && !empty;
    wr_d = wr_q + AW'(push_ok);
    rd_d = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = din;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // a slot is live when its distance from the read pointer is below the occupancy
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [AW-1:0] off;
    assign off = AW'(i) - rd_q;
    assign valid[i] = {1'b0, off} < cnt_q;
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign entries = mem_q;
endmodule

// File: rtl/arbitro_escrita_regs.sv
// arbitro_escrita_regs: merges ALU and load writebacks onto the bank write port, tracks pending loads, drives decode stall
module arbitro_escrita_regs
  import sica_pkg::*;
#(
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic [4:0]                      alu_addr,
  input  logic [31:0]                     alu_data,
  input  logic                            mem_valid,
  output logic                            mem_ready,
  input  logic [4:0]                      mem_addr,
  input  logic [31:0]                     mem_data,
  input  logic                            pend_set,
  input  logic [4:0]                      pend_addr,
  input  logic [4:0]                      rs,
  input  logic [4:0]                      rt,
  output logic                            stall,
  output logic                            we,
  output logic [4:0]                      waddr,
  output logic [31:0]                     wdata,
  output logic [$clog2(ALU_FIFO_DEPTH):0] fifo_count
);
  localparam int SW = $clog2(MAX_WAIT + 1);
  wr_t alu_req, mem_req, head, cand, out_q, out_d;
  wr_t [ALU_FIFO_DEPTH-1:0] entries;
  logic [ALU_FIFO_DEPTH-1:0] ent_valid;
  logic fifo_full, fifo_empty, push, pop, bypass, mem_win, alu_win, q_hit;
  logic we_q, we_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0] pend_q, pend_d;
  fila_escrita #(.DEPTH(ALU_FIFO_DEPTH)) u_fila (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .din     (alu_req),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .entries (entries),
    .valid   (ent_valid)
  );
  assign alu_req = '{addr: alu_addr, data: alu_data};
  assign mem_req = '{addr: mem_addr, data: mem_data};
  always_comb begin
    alu_ready = !fifo_full;
    mem_ready = !(starve_q == SW'(MAX_WAIT) && !fifo_empty);
    mem_win = mem_valid && mem_ready;
    bypass = fifo_empty && alu_valid && !mem_win;
    pop = !mem_win && !fifo_empty;
    push = alu_valid && !fifo_full && !bypass;
    alu_win = pop || bypass;
    cand = fifo_empty ? alu_req : head;
    starve_d = (fifo_empty || alu_win) ? '0 : (starve_q == SW'(MAX_WAIT)) ? starve_q : starve_q + SW'(1);
    we_d = mem_win || alu_win;
    out_d = mem_win ? mem_req : alu_win ? cand : out_q;
    // set is applied after clear so a same-cycle set survives
    pend_d = (pend_q & ~(mem_win ? 32'(1) << mem_addr : 32'(0))) | (pend_set ? 32'(1) << pend_addr : 32'(0));
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q <= 1'b0;
      out_q <= '0;
      starve_q <= '0;
      pend_q <= '0;
    end else begin
      we_q <= we_d;
      out_q <= out_d;
      starve_q <= starve_d;
      pend_q <= pend_d;
    end
  end
  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < ALU_FIFO_DEPTH; i++)
      q_hit = q_hit | (ent_valid[i] && (entries[i].addr == rs || entries[i].addr == rt));
    stall = pend_q[rs] | pend_q[rt] | q_hit | (we_q && (out_q.addr == rs || out_q.addr == rt));
  end
  assign we = we_q;
  assign waddr = out_q.addr;
  assign wdata = out_q.data;
endmodule

// File: tb/tb_arbitro_escrita_regs.sv
// tb_arbitro_escrita_regs: directed-vector bench for the register-bank write arbiter
module tb_arbitro_escrita_regs;
  logic clock, reset;
  logic alu_valid, alu_ready, mem_valid, mem_ready, pend_set, stall, we;
  logic [4:0] alu_addr, mem_addr, pend_addr, rs, rt, waddr;
  logic [31:0] alu_data, mem_data, wdata;
  logic [1:0] fifo_count;
  logic [31:0] bank [32];
  int n_wr = 0;
  int n_chk = 0;
  int n_fail = 0;
  int w0;

  arbitro_escrita_regs #(.ALU_FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .rs(rs), .rt(rt), .stall(stall),
    .we(we), .waddr(waddr), .wdata(wdata), .fifo_count(fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (we) begin
    bank[waddr] <= wdata;
    n_wr <= n_wr + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; pend_set = 0;
  endtask

  initial begin
    reset = 1; idle();
    alu_addr = 0; alu_data = 0; mem_addr = 0; mem_data = 0; pend_addr = 0; rs = 0; rt = 0;
    tick(); tick();
    reset = 0; #1;
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_alu_ready", alu_ready, 1);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_count", fifo_count, 0);

    alu_valid = 1; alu_addr = 5; alu_data = 32'h1234;
    tick(); idle();
    check("byp_we", we, 1);
    check("byp_waddr", waddr, 5);
    check("byp_wdata", wdata, 32'h1234);
    check("byp_count", fifo_count, 0);
    tick();
    check("byp_bank", bank[5], 32'h1234);
    check("byp_we_drop", we, 0);
    check("byp_hold", waddr, 5);

    mem_valid = 1; mem_addr = 3; mem_data = 32'hAA;
    alu_valid = 1; alu_addr = 4; alu_data = 32'hBB;
    tick(); idle();
    check("mix_mem_addr", waddr, 3);
    check("mix_mem_data", wdata, 32'hAA);
    check("mix_count1", fifo_count, 1);
    rs = 4; #1;
    check("mix_fifo_stall", stall, 1);
    rs = 0;
    tick();
    check("mix_alu_addr", waddr, 4);
    check("mix_alu_data", wdata, 32'hBB);
    check("mix_count0", fifo_count, 0);
    tick();
    check("mix_bank3", bank[3], 32'hAA);
    check("mix_bank4", bank[4], 32'hBB);

    alu_valid = 1; alu_addr = 0; alu_data = 32'h55; #1;
    check("r0_pre_stall", stall, 0);
    tick(); idle();
    check("r0_waddr", waddr, 0);
    check("r0_stall", stall, 1);
    tick();
    check("r0_bank", bank[0], 32'h55);
    check("r0_stall_clr", stall, 0);

    mem_valid = 1; mem_addr = 10; mem_data = 32'h10;
    alu_valid = 1; alu_addr = 11; alu_data = 32'h11;
    tick();
    alu_addr = 12; alu_data = 32'h12; #1;
    check("stv_ready_1", alu_ready, 1);
    tick();
    alu_addr = 13; alu_data = 32'h13; #1;
    check("stv_count2", fifo_count, 2);
    check("stv_full", alu_ready, 0);
    check("stv_mem_win", waddr, 10);
    tick();
    alu_valid = 0;
    check("stv_refused", fifo_count, 2);
    check("stv_mr3", mem_ready, 1);
    tick();
    check("stv_mr4", mem_ready, 1);
    tick();
    check("stv_mr5", mem_ready, 0);
    check("stv_still_mem", waddr, 10);
    tick();
    check("stv_head_addr", waddr, 11);
    check("stv_head_data", wdata, 32'h11);
    check("stv_count1", fifo_count, 1);
    check("stv_mr_back", mem_ready, 1);
    mem_valid = 0;
    tick();
    check("stv_order_addr", waddr, 12);
    check("stv_order_data", wdata, 32'h12);
    check("stv_count0", fifo_count, 0);
    tick();

    pend_set = 1; pend_addr = 7; rs = 7; #1;
    check("pend_pre", stall, 0);
    tick(); pend_set = 0; #1;
    check("pend_stall", stall, 1);
    tick();
    check("pend_hold", stall, 1);
    mem_valid = 1; mem_addr = 7; mem_data = 32'h77; pend_set = 1;
    tick(); idle();
    check("pend_grant", waddr, 7);
    tick();
    check("pend_set_wins", stall, 1);
    rs = 0; rt = 7; #1;
    check("pend_rt", stall, 1);
    mem_valid = 1; mem_addr = 7; mem_data = 32'h78;
    tick(); idle();
    check("pend_inflight", stall, 1);
    tick();
    check("pend_clear", stall, 0);
    check("pend_bank", bank[7], 32'h78);
    rt = 0;

    mem_valid = 1; mem_addr = 20; mem_data = 32'h20;
    alu_valid = 1; alu_addr = 21; alu_data = 32'h21;
    pend_set = 1; pend_addr = 9;
    tick();
    pend_set = 0; alu_addr = 22; alu_data = 32'h22;
    tick();
    alu_valid = 0; rs = 9; #1;
    check("ar_pre_count", fifo_count, 2);
    check("ar_pre_stall", stall, 1);
    #1 reset = 1; #1;
    w0 = n_wr;
    check("ar_count", fifo_count, 0);
    check("ar_we", we, 0);
    check("ar_stall", stall, 0);
    check("ar_alu_ready", alu_ready, 1);
    idle();
    tick(); tick();
    reset = 0;
    tick(); tick(); tick();
    check("ar_no_write", n_wr, w0);
    check("ar_idle_count", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
